// File: rtl/dsp_mac_seq.sv
// Operand sequencer that drives a DSP48A1 slice as a multiply-accumulate engine.
// Define DSP_MAC_SAT_EN to clamp the result to the signed 36-bit range.
module dsp_mac_seq #(
    parameter int unsigned N_MAX    = 16,
    parameter int unsigned LAT      = 4,
    parameter int unsigned OPM_SKEW = 2,
    localparam int unsigned LW      = $clog2(N_MAX) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          err,
    output logic          busy,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [17:0]   s_a,
    input  logic [17:0]   s_b,
    output logic [17:0]   dsp_a,
    output logic [17:0]   dsp_b,
    output logic [17:0]   dsp_d,
    output logic [7:0]    dsp_opmode,
    output logic          dsp_ce,
    output logic          dsp_carryin,
    input  logic [47:0]   dsp_p,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [47:0]   res_data,
    output logic          res_sat
);

    localparam int unsigned DRAIN_LEN = LAT + OPM_SKEW + 1;
    localparam int unsigned DW        = $clog2(DRAIN_LEN);
    localparam logic [7:0]  OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0]  OPM_ACC   = 8'b0000_1001;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t                   state;
    logic [LW-1:0]            cnt;
    logic [DW-1:0]            dcnt;
    logic                     first;
    // Element 0 travels with dsp_a/dsp_b; the last element is what the slice sees.
    logic [OPM_SKEW:0][7:0]   opm_pipe;
    logic                     len_ok;
    logic                     xfer;
    logic [47:0]              cap_data;
    logic                     cap_sat;

    assign len_ok      = (len != '0) && (len <= LW'(N_MAX));
    assign xfer        = s_valid && s_ready;
    assign dsp_opmode  = opm_pipe[OPM_SKEW];
    assign dsp_d       = '0;
    assign dsp_carryin = 1'b0;

`ifdef DSP_MAC_SAT_EN
    localparam logic signed [47:0] SAT_HI = 48'sh0007_FFFF_FFFF;
    localparam logic signed [47:0] SAT_LO = -48'sh0008_0000_0000;

    always_comb begin
        cap_data = dsp_p;
        cap_sat  = 1'b0;
        if ($signed(dsp_p) > SAT_HI) begin
            cap_data = SAT_HI;
            cap_sat  = 1'b1;
        end else if ($signed(dsp_p) < SAT_LO) begin
            cap_data = SAT_LO;
            cap_sat  = 1'b1;
        end
    end
`else
    assign cap_data = dsp_p;
    assign cap_sat  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            first     <= 1'b0;
            opm_pipe  <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            s_ready   <= 1'b0;
            dsp_a     <= '0;
            dsp_b     <= '0;
            dsp_ce    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
        end else begin
            err    <= 1'b0;
            dsp_ce <= 1'b0;
            // OPMODE stages advance only when the slice itself advances
            if (dsp_ce) begin
                opm_pipe[OPM_SKEW:1] <= opm_pipe[OPM_SKEW-1:0];
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state   <= ISSUE;
                            cnt     <= len;
                            first   <= 1'b1;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        dsp_a       <= s_a;
                        dsp_b       <= s_b;
                        dsp_ce      <= 1'b1;
                        opm_pipe[0] <= first ? OPM_FIRST : OPM_ACC;
                        first       <= 1'b0;
                        cnt         <= cnt - LW'(1);
                        if (cnt == LW'(1)) begin
                            state   <= DRAIN;
                            s_ready <= 1'b0;
                            dcnt    <= DW'(DRAIN_LEN - 1);
                        end
                    end
                end
                DRAIN: begin
                    dsp_a       <= '0;
                    dsp_b       <= '0;
                    opm_pipe[0] <= OPM_ACC;
                    if (dcnt == '0) begin
                        state     <= HOLD;
                        res_valid <= 1'b1;
                        res_data  <= cap_data;
                        res_sat   <= cap_sat;
                    end else begin
                        dsp_ce <= 1'b1;
                        dcnt   <= dcnt - DW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: behavioural DSP48A1 slice, table vectors, hand sequences
// and random jobs checked against a sum-of-products reference.
module tb_dsp_mac_seq;

    localparam int unsigned LW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          err;
    logic          busy;
    logic          s_valid;
    logic          s_ready;
    logic [17:0]   s_a;
    logic [17:0]   s_b;
    logic [17:0]   dsp_a;
    logic [17:0]   dsp_b;
    logic [17:0]   dsp_d;
    logic [7:0]    dsp_opmode;
    logic          dsp_ce;
    logic          dsp_carryin;
    logic [47:0]   dsp_p;
    logic          res_valid;
    logic          res_ready;
    logic [47:0]   res_data;
    logic          res_sat;

    int checks;
    int failures;

    dsp_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .err(err), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_carryin(dsp_carryin), .dsp_p(dsp_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat)
    );

    always #5 clk = ~clk;

    // Slice model: product is 4 enabled cycles behind A/B capture, OPMODE 2 behind.
    logic        [47:0] p_reg;
    logic        [47:0] ppipe [4];
    logic        [7:0]  opipe [2];
    logic signed [47:0] m_new;
    logic        [47:0] x_mux;
    logic        [47:0] z_mux;

    assign m_new = 48'($signed(dsp_a)) * 48'($signed(dsp_b));
    assign x_mux = (opipe[1][1:0] == 2'b01) ? ppipe[3] : 48'd0;
    assign z_mux = (opipe[1][3:2] == 2'b10) ? p_reg : 48'd0;
    assign dsp_p = p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
            for (int i = 0; i < 4; i++) ppipe[i] <= '0;
            for (int i = 0; i < 2; i++) opipe[i] <= '0;
        end else if (dsp_ce) begin
            p_reg    <= z_mux + x_mux;
            ppipe[0] <= m_new;
            ppipe[1] <= ppipe[0];
            ppipe[2] <= ppipe[1];
            ppipe[3] <= ppipe[2];
            opipe[0] <= dsp_opmode;
            opipe[1] <= opipe[0];
        end
    end

    logic signed [17:0] ja [16];
    logic signed [17:0] jb [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed sum of products, 48-bit wrap, optional 36-bit clamp.
    function automatic logic [48:0] ref_model(input int n);
        longint acc;
        acc = 0;
        for (int i = 0; i < n; i++) acc += longint'(ja[i]) * longint'(jb[i]);
        acc = (acc <<< 16) >>> 16;
`ifdef DSP_MAC_SAT_EN
        if (acc > 64'sd34359738367) return {1'b1, 48'h0007_FFFF_FFFF};
        if (acc < -64'sd34359738368) return {1'b1, 48'hFFF8_0000_0000};
`endif
        return {1'b0, acc[47:0]};
    endfunction

    // Called just after a rising edge; returns in the first cycle RES_VALID is seen.
    task automatic run_job(input int n, input int gap_after, input int gap_len, input logic rdy,
                           output int cyc, output int ce0);
        int k;
        int g;
        k = 0; g = 0; cyc = 0; ce0 = 0;
        res_ready = rdy;
        start = 1'b1;
        len = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len = LW'($urandom);
        cyc = 1;
        while (!res_valid && cyc < 300) begin
            if (s_ready && k >= 1 && !dsp_ce) ce0++;
            if (s_ready && k < n && !(k == gap_after && g < gap_len)) begin
                s_valid = 1'b1;
                s_a = ja[k];
                s_b = jb[k];
                k++;
            end else begin
                if (s_ready && k == gap_after) g++;
                s_valid = 1'b0;
                s_a = 18'($urandom);
                s_b = 18'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        check("job_done", 64'(res_valid), 64'(1));
        check("const_outs", 64'({dsp_d, dsp_carryin}), 64'(0));
    endtask

    task automatic check_result(input logic [48:0] exp, input int n, input int gl,
                                input int cyc, input int ce0);
        check("res_data", 64'(res_data), 64'(exp[47:0]));
        check("res_sat", 64'(res_sat), 64'(exp[48]));
        check("latency", 64'(cyc), 64'(n + 8 + gl));
        check("ce_gap", 64'(ce0), 64'(gl));
        @(posedge clk); #1;
        check("idle_after", 64'({busy, res_valid, s_ready}), 64'(0));
    endtask

    typedef struct {
        int              n;
        logic [2:0][17:0] a;
        logic [2:0][17:0] b;
        int              gap_after;
        int              gap_len;
        logic [47:0]     exp;
    } vec_t;

    vec_t tbl [4];
    int   cyc;
    int   ce0;

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; rst_n = 1'b0;
        start = 1'b0; len = '0; s_valid = 1'b0; s_a = '0; s_b = '0; res_ready = 1'b0;

        tbl[0].n = 1; tbl[0].gap_after = -1; tbl[0].gap_len = 0; tbl[0].exp = 48'h0000_0000_001E;
        tbl[0].a = {18'h0, 18'h0, 18'd5};
        tbl[0].b = {18'h0, 18'h0, 18'd6};
        tbl[1].n = 3; tbl[1].gap_after = 1; tbl[1].gap_len = 3; tbl[1].exp = 48'h0000_0000_00D1;
        tbl[1].a = {18'h3FFFD, 18'd5, 18'd20};
        tbl[1].b = {18'd7, 18'd6, 18'd10};
        tbl[2].n = 2; tbl[2].gap_after = 1; tbl[2].gap_len = 1; tbl[2].exp = 48'hFFFF_FFFF_FFE2;
        tbl[2].a = {18'h0, 18'd0, 18'h3FFFB};
        tbl[2].b = {18'h0, 18'd100, 18'd6};
        tbl[3].n = 1; tbl[3].gap_after = -1; tbl[3].gap_len = 0; tbl[3].exp = 48'hFFFC_0002_0000;
        tbl[3].a = {18'h0, 18'h0, 18'h20000};
        tbl[3].b = {18'h0, 18'h0, 18'h1FFFF};

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom); len = LW'($urandom); s_valid = 1'($urandom);
            s_a = 18'($urandom); s_b = 18'($urandom); res_ready = 1'($urandom);
            @(negedge clk);
            check("rst_ctrl", 64'({err, busy, s_ready, dsp_ce, res_valid, res_sat, dsp_carryin}), 64'(0));
            check("rst_dsp", 64'({dsp_a, dsp_b, dsp_d, dsp_opmode}), 64'(0));
            check("rst_res", 64'(res_data), 64'(0));
        end
        start = 1'b0; s_valid = 1'b0; res_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                ja[j] = tbl[i].a[j];
                jb[j] = tbl[i].b[j];
            end
            run_job(tbl[i].n, tbl[i].gap_after, tbl[i].gap_len, 1'b1, cyc, ce0);
            check_result({1'b0, tbl[i].exp}, tbl[i].n, tbl[i].gap_len, cyc, ce0);
        end

        // Result held while RES_READY is low; START in HOLD is ignored
        ja[0] = 18'sd7; jb[0] = 18'sd9; ja[1] = 18'sd8; jb[1] = -18'sd1;
        run_job(2, -1, 0, 1'b0, cyc, ce0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = LW'(1);
            @(posedge clk); #1;
            check("hold_valid", 64'(res_valid), 64'(1));
            check("hold_data", 64'(res_data), 64'h37);
            check("hold_busy_err", 64'({busy, err, s_ready}), 64'b100);
        end
        res_ready = 1'b1; start = 1'b1; len = LW'(1);
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b0;
        check("handshake_idle", 64'({busy, res_valid, s_ready}), 64'(0));
        @(posedge clk); #1;
        check("start_ignored", 64'({busy, s_ready, err}), 64'(0));

        // Illegal lengths
        start = 1'b1; len = LW'(0);
        @(posedge clk); #1;
        start = 1'b0;
        check("err_len0", 64'({err, busy}), 64'b10);
        @(posedge clk); #1;
        check("err_pulse_end", 64'({err, busy}), 64'(0));
        start = 1'b1; len = LW'(17);
        @(posedge clk); #1;
        start = 1'b0;
        check("err_len17", 64'({err, busy}), 64'b10);
        @(posedge clk); #1;

        // Reset in the middle of a job
        start = 1'b1; len = LW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_a = 18'(i + 1); s_b = 18'(i + 2);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({err, busy, s_ready, dsp_ce, res_valid}), 64'(0));
        check("midrst_dsp", 64'({dsp_a, dsp_b, dsp_opmode}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ja[0] = 18'sd3; jb[0] = 18'sd4;
        run_job(1, -1, 0, 1'b1, cyc, ce0);
        check_result({1'b0, 48'h0000_0000_000C}, 1, 0, cyc, ce0);

        // Full-length job at the largest positive operands
        for (int j = 0; j < 16; j++) begin
            ja[j] = 18'h1FFFF;
            jb[j] = 18'h1FFFF;
        end
        run_job(16, -1, 0, 1'b1, cyc, ce0);
`ifdef DSP_MAC_SAT_EN
        check_result({1'b1, 48'h0007_FFFF_FFFF}, 16, 0, cyc, ce0);
`else
        check_result({1'b0, 48'h003F_FFC0_0010}, 16, 0, cyc, ce0);
`endif

        // Random jobs against the reference
        for (int t = 0; t < 24; t++) begin
            int          n;
            int          ga;
            int          gl;
            logic [48:0] exp;
            n = $urandom_range(1, 16);
            for (int j = 0; j < 16; j++) begin
                ja[j] = 18'($urandom);
                jb[j] = 18'($urandom);
            end
            if (n > 1) begin
                ga = $urandom_range(1, n - 1);
                gl = $urandom_range(0, 3);
            end else begin
                ga = -1;
                gl = 0;
            end
            exp = ref_model(n);
            run_job(n, ga, gl, 1'b1, cyc, ce0);
            check_result(exp, n, gl, cyc, ce0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
